// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory data-port arbiter:
// memory write/size codes, FSM state encoding and owner identifiers.
package mem_port_arbiter_pkg;

    localparam logic [1:0] MEM_WR_NONE = 2'b00;
    localparam logic [1:0] MEM_WR_BYTE = 2'b01;
    localparam logic [1:0] MEM_WR_HALF = 2'b10;
    localparam logic [1:0] MEM_WR_WORD = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    localparam logic ARB_OWNER_C = 1'b0;
    localparam logic ARB_OWNER_L = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Two-input request selector: a lone requester wins outright,
// a tie goes to the port named by the pointer input.
module arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic c_req,
    input  logic l_req,
    input  logic pointer,
    output logic grant_valid,
    output logic grant_id
);

    // Pick the winner among the active requests.
    always_comb begin
        grant_valid = c_req | l_req;
        grant_id    = ARB_OWNER_C;
        if (c_req && l_req) begin
            grant_id = pointer;
        end else if (l_req) begin
            grant_id = ARB_OWNER_L;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU (C) and loader (L) accesses onto the single memory data port.
// Define MEM_ARB_RR_EN for round-robin ties; otherwise C always wins ties.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          C_REQ,
    input  logic [1:0]    C_WR,
    input  logic [AW-1:0] C_ADDR,
    input  logic [DW-1:0] C_DATA,
    output logic          C_ACK,
    output logic [DW-1:0] C_RDATA,
    input  logic          L_REQ,
    input  logic [1:0]    L_WR,
    input  logic [AW-1:0] L_ADDR,
    input  logic [DW-1:0] L_DATA,
    output logic          L_ACK,
    output logic [DW-1:0] L_RDATA,
    output logic [1:0]    M_WR,
    output logic [AW-1:0] M_IN_ADDR,
    output logic [AW-1:0] M_OUT_ADDR,
    output logic [DW-1:0] M_D_IN,
    input  logic [DW-1:0] M_D_OUT,
    output logic          BUSY,
    output logic          OWNER
);

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic          owner_q;
    logic [1:0]    lat_wr;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_data;
    logic [DW-1:0] c_rdata_q;
    logic [DW-1:0] l_rdata_q;
    logic          grant_valid;
    logic          grant_id;
    logic          grant;
    logic          rr_ptr;

    assign grant = (state_q == ARB_IDLE) && grant_valid;

`ifdef MEM_ARB_RR_EN
    // After each grant, point the tie-break at the port that did not win.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr <= ARB_OWNER_C;
        end else if (grant) begin
            rr_ptr <= ~grant_id;
        end
    end
`else
    assign rr_ptr = ARB_OWNER_C;
`endif

    arb_pick u_pick (
        .c_req       (C_REQ),
        .l_req       (L_REQ),
        .pointer     (rr_ptr),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the winner's request at the grant edge so later input changes are ignored.
    always_ff @(posedge CLK) begin
        if (RST) begin
            owner_q  <= ARB_OWNER_C;
            lat_wr   <= MEM_WR_NONE;
            lat_addr <= '0;
            lat_data <= '0;
        end else if (grant) begin
            owner_q <= grant_id;
            if (grant_id == ARB_OWNER_L) begin
                lat_wr   <= L_WR;
                lat_addr <= L_ADDR;
                lat_data <= L_DATA;
            end else begin
                lat_wr   <= C_WR;
                lat_addr <= C_ADDR;
                lat_data <= C_DATA;
            end
        end
    end

    // Keep the owner's read data after its ACK cycle; the other port holds its value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            c_rdata_q <= '0;
            l_rdata_q <= '0;
        end else if (state_q == ARB_RESP) begin
            if (owner_q == ARB_OWNER_L) begin
                l_rdata_q <= M_D_OUT;
            end else begin
                c_rdata_q <= M_D_OUT;
            end
        end
    end

    // Next-state logic: one ACCESS and one RESP cycle per grant.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE:   if (grant_valid) state_d = ARB_ACCESS;
            ARB_ACCESS: state_d = ARB_RESP;
            ARB_RESP:   state_d = ARB_IDLE;
            default:    state_d = ARB_IDLE;
        endcase
    end

    // Outputs: write code only in ACCESS, ACK and live read data only in RESP.
    always_comb begin
        M_WR       = MEM_WR_NONE;
        M_IN_ADDR  = lat_addr;
        M_OUT_ADDR = lat_addr;
        M_D_IN     = lat_data;
        C_ACK      = 1'b0;
        L_ACK      = 1'b0;
        C_RDATA    = c_rdata_q;
        L_RDATA    = l_rdata_q;
        BUSY       = (state_q != ARB_IDLE);
        OWNER      = owner_q;
        unique case (state_q)
            ARB_ACCESS: M_WR = lat_wr;
            ARB_RESP: begin
                if (owner_q == ARB_OWNER_L) begin
                    L_ACK   = 1'b1;
                    L_RDATA = M_D_OUT;
                end else begin
                    C_ACK   = 1'b1;
                    C_RDATA = M_D_OUT;
                end
            end
            default: ;
        endcase
    end

endmodule
